regfile_mp: RTL and testbench

Parametrised multi-port register file for the pipelined core and its successors. Supports configurable width, depth, read ports and write ports. Reads are registered, writes land on the rising edge, and an internal sweep FSM zero-fills the array after reset or on request. Sits in the decode/writeback boundary and replaces the fixed 2R1W falling-edge-write file.

---
 rtl/regfile_mp.sv | 117 +++++++++++
 tb/tb_regfile_mp.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: registered reads, rising-edge writes, zero-fill sweep.
// Optional build macro REGFILE_BYPASS_EN enables same-edge write-to-read forwarding.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clear,
  input  logic [NRD-1:0]       i_re,
  input  logic [NRD*AW-1:0]    i_ra,
  output logic [NRD*XLEN-1:0]  o_rd,
  input  logic [NWR-1:0]       i_we,
  input  logic [NWR*AW-1:0]    i_wa,
  input  logic [NWR*XLEN-1:0]  i_wd,
  output logic                 o_busy
);

  localparam logic [AW-1:0] CNT_LAST = AW'(NREGS - 1);
  localparam logic          ZERO_EN  = (ZERO_REG != 0);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]     mem [NREGS];
  logic [NRD*XLEN-1:0] rd_d, rd_p1;
  logic [AW-1:0]       ra;
  logic                clearing;

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return ZERO_EN && (a == '0);
  endfunction

  assign clearing = (state_q == ST_CLEAR);
  assign o_busy   = clearing;
  assign o_rd     = rd_p1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // i_clear is only honoured from IDLE, so a request mid-sweep never restarts it
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        if (i_clear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Array has no reset; later write ports overwrite earlier ones on a shared address
  always_ff @(posedge i_clk) begin
    if (clearing) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (i_we[j] && !is_zero_reg(i_wa[j*AW +: AW]))
          mem[i_wa[j*AW +: AW]] <= i_wd[j*XLEN +: XLEN];
      end
    end
  end

  // Read stage p0 -> p1: array is sampled before this edge's writes land
  always_comb begin
    rd_d = rd_p1;
    ra   = '0;
    for (int k = 0; k < NRD; k++) begin
      if (i_re[k]) begin
        ra = i_ra[k*AW +: AW];
        if (clearing || is_zero_reg(ra))
          rd_d[k*XLEN +: XLEN] = '0;
        else
          rd_d[k*XLEN +: XLEN] = mem[ra];
`ifdef REGFILE_BYPASS_EN
        if (!clearing && !is_zero_reg(ra)) begin
          for (int j = 0; j < NWR; j++) begin
            if (i_we[j] && (i_wa[j*AW +: AW] == ra))
              rd_d[k*XLEN +: XLEN] = i_wd[j*XLEN +: XLEN];
          end
        end
`else
        // Read-before-write: the new value appears on the next read
`endif
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rd_p1 <= '0;
    else          rd_p1 <= rd_d;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (2 read ports, 2 write ports, x0 hardwired).
// Expected values follow the REGFILE_BYPASS_EN setting of the build.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int AW = 5;

  logic                 i_clk = 1'b0;
  logic                 i_rst_n = 1'b1;
  logic                 i_clear = 1'b0;
  logic [NRD-1:0]       i_re = '0;
  logic [NRD*AW-1:0]    i_ra = '0;
  logic [NRD*XLEN-1:0]  o_rd;
  logic [NWR-1:0]       i_we = '0;
  logic [NWR*AW-1:0]    i_wa = '0;
  logic [NWR*XLEN-1:0]  i_wd = '0;
  logic                 o_busy;

  int checks = 0;
  int errors = 0;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear),
    .i_re(i_re), .i_ra(i_ra), .o_rd(o_rd),
    .i_we(i_we), .i_wa(i_wa), .i_wd(i_wd), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_rd(input int k, input logic en, input logic [AW-1:0] a);
    i_re[k] = en;
    i_ra[k*AW +: AW] = a;
  endtask

  task automatic set_wr(input int j, input logic en, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    i_we[j] = en;
    i_wa[j*AW +: AW] = a;
    i_wd[j*XLEN +: XLEN] = d;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (o_busy && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    set_rd(0, 1'b1, 5'd5);
    set_rd(1, 1'b1, 5'd7);
    #2 i_rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (o_rd !== 64'h0) begin
      errors++; $display("FAIL reset_rd got %h exp %h", o_rd, 64'h0);
    end
    checks++;
    if (o_busy !== 1'b1) begin
      errors++; $display("FAIL reset_busy got %b exp 1", o_busy);
    end
    i_re = '0;
    i_rst_n = 1'b1;
    wait_idle(n);
    checks++;
    if (n != 32) begin
      errors++; $display("FAIL reset_sweep_len got %0d exp 32", n);
    end
    set_rd(0, 1'b1, 5'd5);
    tick();
    i_re = '0;
    checks++;
    if (o_rd[31:0] !== 32'h0) begin
      errors++; $display("FAIL post_reset_x5 got %h exp %h", o_rd[31:0], 32'h0);
    end
  endtask

  task automatic test_write_read();
    set_wr(0, 1'b1, 5'd3, 32'hDEADBEEF);
    tick();
    i_we = '0;
    set_rd(0, 1'b1, 5'd3);
    set_rd(1, 1'b1, 5'd0);
    tick();
    checks++;
    if (o_rd[31:0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_rd_x3 got %h exp %h", o_rd[31:0], 32'hDEADBEEF);
    end
    checks++;
    if (o_rd[63:32] !== 32'h0) begin
      errors++; $display("FAIL rd_x0 got %h exp %h", o_rd[63:32], 32'h0);
    end
    i_re = '0;
    set_wr(0, 1'b1, 5'd0, 32'h00001234);
    tick();
    i_we = '0;
    set_rd(0, 1'b1, 5'd0);
    tick();
    i_re = '0;
    checks++;
    if (o_rd[31:0] !== 32'h0) begin
      errors++; $display("FAIL wr_x0_dropped got %h exp %h", o_rd[31:0], 32'h0);
    end
  endtask

  task automatic test_same_edge();
    logic [31:0] exp_first;
`ifdef REGFILE_BYPASS_EN
    exp_first = 32'hAAAA5555;
`else
    exp_first = 32'h0;
`endif
    set_wr(0, 1'b1, 5'd7, 32'hAAAA5555);
    set_rd(0, 1'b1, 5'd7);
    tick();
    i_we = '0;
    checks++;
    if (o_rd[31:0] !== exp_first) begin
      errors++; $display("FAIL same_edge_x7 got %h exp %h", o_rd[31:0], exp_first);
    end
    tick();
    checks++;
    if (o_rd[31:0] !== 32'hAAAA5555) begin
      errors++; $display("FAIL next_read_x7 got %h exp %h", o_rd[31:0], 32'hAAAA5555);
    end
    set_wr(0, 1'b1, 5'd0, 32'h0000FFFF);
    set_rd(0, 1'b1, 5'd0);
    tick();
    i_we = '0;
    i_re = '0;
    checks++;
    if (o_rd[31:0] !== 32'h0) begin
      errors++; $display("FAIL same_edge_x0 got %h exp %h", o_rd[31:0], 32'h0);
    end
  endtask

  task automatic test_multi_write();
    logic [31:0] exp_first;
`ifdef REGFILE_BYPASS_EN
    exp_first = 32'h22;
`else
    exp_first = 32'h0;
`endif
    set_wr(0, 1'b1, 5'd9, 32'h11);
    set_wr(1, 1'b1, 5'd9, 32'h22);
    set_rd(0, 1'b1, 5'd9);
    set_rd(1, 1'b1, 5'd9);
    tick();
    i_we = '0;
    checks++;
    if (o_rd[31:0] !== exp_first) begin
      errors++; $display("FAIL conflict_same_edge got %h exp %h", o_rd[31:0], exp_first);
    end
    tick();
    checks++;
    if (o_rd[63:32] !== 32'h22) begin
      errors++; $display("FAIL conflict_x9 got %h exp %h", o_rd[63:32], 32'h22);
    end
    set_wr(0, 1'b1, 5'd10, 32'h100);
    set_wr(1, 1'b1, 5'd11, 32'h200);
    i_re = '0;
    tick();
    i_we = '0;
    set_rd(0, 1'b1, 5'd11);
    set_rd(1, 1'b1, 5'd10);
    tick();
    i_re = '0;
    checks++;
    if (o_rd !== {32'h100, 32'h200}) begin
      errors++; $display("FAIL dual_write got %h exp %h", o_rd, {32'h100, 32'h200});
    end
  endtask

  task automatic test_clear();
    int n;
    for (int i = 1; i < 32; i++) begin
      set_wr(0, 1'b1, 5'(i), 32'h10000000 + 32'(i));
      tick();
    end
    i_we = '0;
    set_rd(0, 1'b1, 5'd31);
    set_rd(1, 1'b1, 5'd4);
    tick();
    checks++;
    if (o_rd !== {32'h10000004, 32'h1000001F}) begin
      errors++; $display("FAIL fill_check got %h exp %h", o_rd, {32'h10000004, 32'h1000001F});
    end
    i_re = '0;
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    n = 0;
    while (o_busy && n < 100) begin
      set_wr(0, 1'b1, 5'd4, 32'h0BADBAD0);
      set_rd(0, 1'b1, 5'd31);
      i_clear = (n == 5);
      tick();
      n++;
      if (n == 3) begin
        checks++;
        if (o_rd[31:0] !== 32'h0) begin
          errors++; $display("FAIL read_in_clear got %h exp %h", o_rd[31:0], 32'h0);
        end
      end
    end
    i_we = '0;
    i_re = '0;
    i_clear = 1'b0;
    checks++;
    if (n != 32) begin
      errors++; $display("FAIL clear_sweep_len got %0d exp 32", n);
    end
    for (int i = 0; i < 16; i++) begin
      set_rd(0, 1'b1, 5'(2 * i));
      set_rd(1, 1'b1, 5'(2 * i + 1));
      tick();
      checks++;
      if (o_rd !== 64'h0) begin
        errors++; $display("FAIL cleared_pair%0d got %h exp %h", i, o_rd, 64'h0);
      end
    end
    i_re = '0;
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    set_wr(0, 1'b1, 5'd12, 32'h00005A5A);
    tick();
    i_we = '0;
    set_rd(0, 1'b1, 5'd12);
    tick();
    i_re = '0;
    checks++;
    if (o_rd[31:0] !== 32'h00005A5A) begin
      errors++; $display("FAIL pre_reset_x12 got %h exp %h", o_rd[31:0], 32'h00005A5A);
    end
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    i_rst_n = 1'b0;
    #2;
    checks++;
    if (o_rd !== 64'h0) begin
      errors++; $display("FAIL async_reset_rd got %h exp %h", o_rd, 64'h0);
    end
    checks++;
    if (o_busy !== 1'b1) begin
      errors++; $display("FAIL mid_reset_busy got %b exp 1", o_busy);
    end
    tick();
    tick();
    i_rst_n = 1'b1;
    wait_idle(n);
    checks++;
    if (n != 32) begin
      errors++; $display("FAIL restart_sweep_len got %0d exp 32", n);
    end
  endtask

  task automatic test_read_hold();
    set_wr(0, 1'b1, 5'd20, 32'hCAFEF00D);
    set_wr(1, 1'b1, 5'd21, 32'h13572468);
    tick();
    i_we = '0;
    set_rd(0, 1'b1, 5'd20);
    set_rd(1, 1'b1, 5'd21);
    tick();
    for (int i = 0; i < 5; i++) begin
      set_rd(0, 1'b0, 5'(i + 1));
      set_rd(1, 1'b0, 5'(i + 24));
      tick();
      checks++;
      if (o_rd !== {32'h13572468, 32'hCAFEF00D}) begin
        errors++; $display("FAIL hold_cycle%0d got %h exp %h", i, o_rd, {32'h13572468, 32'hCAFEF00D});
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_same_edge();
    test_multi_write();
    test_clear();
    test_reset_mid_sweep();
    test_read_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
